// File: rtl/skipper_cds_accum.sv
// Skipper-CCD correlated double sampling accumulator: sums (SIG - PED) over a
// programmable number of skips per pixel and presents the result on a valid/ready register.
module skipper_cds_accum #(
    parameter int ADC_WIDTH = 16,
    parameter int ACC_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sprocket_PED,
    input  logic                        sprocket_SIG,
    input  logic signed [ADC_WIDTH-1:0] adc_data,
    input  logic                        adc_valid,
    input  logic [9:0]                  skip_samples,
    input  logic                        clear_err,
    output logic signed [ACC_WIDTH-1:0] pix_data,
    output logic                        pix_valid,
    input  logic                        pix_ready,
    output logic [15:0]                 pix_index,
    output logic                        busy,
    output logic                        protocol_err,
    output logic                        overrun_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM_PED  = 2'd1,
        WAIT_SIG = 2'd2,
        ARM_SIG  = 2'd3
    } state_t;

    state_t                      state;
    logic                        ped_d;
    logic                        sig_d;
    logic                        ped_edge;
    logic                        sig_edge;
    logic                        both_edge;
    logic                        proto_set;
    logic                        overrun_set;
    logic                        out_blocked;
    logic signed [ADC_WIDTH-1:0] ped;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic [9:0]                  skip_cnt;
    logic [9:0]                  skip_cnt_next;
    logic [9:0]                  skip_target;
    logic                        pub_p1;
    logic [15:0]                 pix_cnt;

    // Difference is formed one bit wider than the ADC so full-scale swings never wrap.
    function automatic logic signed [ACC_WIDTH-1:0] cds_diff(
        input logic signed [ADC_WIDTH-1:0] sig,
        input logic signed [ADC_WIDTH-1:0] ped_val
    );
        logic [ADC_WIDTH:0] d;
        d = {sig[ADC_WIDTH-1], sig} - {ped_val[ADC_WIDTH-1], ped_val};
        return {{(ACC_WIDTH-ADC_WIDTH-1){d[ADC_WIDTH]}}, d};
    endfunction

    always_comb begin
        ped_edge      = sprocket_PED & ~ped_d;
        sig_edge      = sprocket_SIG & ~sig_d;
        both_edge     = ped_edge & sig_edge;
        proto_set     = both_edge | (sig_edge & ((state == IDLE) || (state == ARM_PED)));
        acc_next      = acc + cds_diff(adc_data, ped);
        skip_cnt_next = skip_cnt + 10'd1;
        out_blocked   = pix_valid & ~pix_ready;
        overrun_set   = pub_p1 & out_blocked;
    end

    assign busy = (state != IDLE);

    // Stage 0: strobe edge detection and per-pixel sequencing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_d       <= 1'b0;
            sig_d       <= 1'b0;
            state       <= IDLE;
            ped         <= '0;
            acc         <= '0;
            skip_cnt    <= '0;
            skip_target <= 10'd1;
            pub_p1      <= 1'b0;
        end else begin
            ped_d  <= sprocket_PED;
            sig_d  <= sprocket_SIG;
            pub_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (ped_edge && !sig_edge) begin
                        state       <= ARM_PED;
                        skip_target <= (skip_samples == 10'd0) ? 10'd1 : skip_samples;
                        acc         <= '0;
                        skip_cnt    <= '0;
                    end
                end
                ARM_PED: begin
                    if (adc_valid) begin
                        ped   <= adc_data;
                        state <= WAIT_SIG;
                    end
                end
                WAIT_SIG: begin
                    if (!both_edge) begin
                        if (sig_edge) begin
                            state <= ARM_SIG;
                        end else if (ped_edge) begin
                            state <= ARM_PED;
                        end
                    end
                end
                ARM_SIG: begin
                    if (adc_valid) begin
                        acc      <= acc_next;
                        skip_cnt <= skip_cnt_next;
                        if (skip_cnt_next == skip_target) begin
                            state  <= IDLE;
                            pub_p1 <= 1'b1;
                        end else begin
                            state <= WAIT_SIG;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 1: output register; acc still holds the final sum here even if a new pixel starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_index <= '0;
            pix_cnt   <= '0;
        end else begin
            if (pub_p1 && !out_blocked) begin
                pix_valid <= 1'b1;
                pix_data  <= acc;
                pix_index <= pix_cnt;
                pix_cnt   <= pix_cnt + 16'd1;
            end else if (pix_valid && pix_ready) begin
                pix_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            protocol_err <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            if (proto_set) begin
                protocol_err <= 1'b1;
            end else if (clear_err) begin
                protocol_err <= 1'b0;
            end
            if (overrun_set) begin
                overrun_err <= 1'b1;
            end else if (clear_err) begin
                overrun_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_skipper_cds_accum.sv
// Directed bench for skipper_cds_accum: a table of whole pixels plus hand-written
// sequences for overrun, protocol errors, delayed ADC data and reset behaviour.
module tb_skipper_cds_accum;

    logic               clk;
    logic               reset;
    logic               sprocket_PED;
    logic               sprocket_SIG;
    logic signed [15:0] adc_data;
    logic               adc_valid;
    logic [9:0]         skip_samples;
    logic               clear_err;
    logic signed [31:0] pix_data;
    logic               pix_valid;
    logic               pix_ready;
    logic [15:0]        pix_index;
    logic               busy;
    logic               protocol_err;
    logic               overrun_err;

    skipper_cds_accum #(.ADC_WIDTH(16), .ACC_WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .sprocket_PED (sprocket_PED),
        .sprocket_SIG (sprocket_SIG),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .skip_samples (skip_samples),
        .clear_err    (clear_err),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_index    (pix_index),
        .busy         (busy),
        .protocol_err (protocol_err),
        .overrun_err  (overrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]        skip;
        logic [9:0][15:0]  peds;
        logic [9:0][15:0]  sigs;
        logic [31:0]       exp_data;
    } vec_t;

    vec_t vecs [6];
    int   n_checks;
    int   n_pass;
    int   exp_index;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One PED/SIG pair; returns just after the edge on which SIG was captured.
    task automatic do_pair(input logic [15:0] p, input logic [15:0] s);
        sprocket_PED = 1'b1; adc_valid = 1'b1; adc_data = p;
        tick(); tick();
        sprocket_PED = 1'b0; adc_valid = 1'b0;
        tick();
        sprocket_SIG = 1'b1; adc_valid = 1'b1; adc_data = s;
        tick(); tick();
        sprocket_SIG = 1'b0; adc_valid = 1'b0; adc_data = 16'h5A5A;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        n_checks = 0; n_pass = 0; exp_index = 0;
        reset = 1'b1; sprocket_PED = 1'b0; sprocket_SIG = 1'b0;
        adc_data = '0; adc_valid = 1'b0; skip_samples = 10'd1;
        clear_err = 1'b0; pix_ready = 1'b1;

        vecs[0] = '0; vecs[0].skip = 10'd3;
        vecs[0].peds[0] = 16'd100; vecs[0].sigs[0] = 16'd150;
        vecs[0].peds[1] = 16'd102; vecs[0].sigs[1] = 16'd149;
        vecs[0].peds[2] = 16'd98;  vecs[0].sigs[2] = 16'd151;
        vecs[0].exp_data = 32'd150;
        vecs[1] = '0; vecs[1].skip = 10'd0;
        vecs[1].peds[0] = -16'sd200; vecs[1].sigs[0] = -16'sd50;
        vecs[1].exp_data = 32'd150;
        vecs[2] = '0; vecs[2].skip = 10'd1;
        vecs[2].peds[0] = 16'h7FFF; vecs[2].sigs[0] = 16'h8000;
        vecs[2].exp_data = 32'hFFFF_0001;
        vecs[3] = '0; vecs[3].skip = 10'd2;
        vecs[3].peds[0] = 16'h8000; vecs[3].sigs[0] = 16'h7FFF;
        vecs[3].peds[1] = 16'h8000; vecs[3].sigs[1] = 16'h7FFF;
        vecs[3].exp_data = 32'd131070;
        vecs[4] = '0; vecs[4].skip = 10'd10;
        for (int i = 0; i < 10; i++) begin
            vecs[4].peds[i] = 16'(i * 10);
            vecs[4].sigs[i] = 16'(i * 11 + 1);
        end
        vecs[4].exp_data = 32'd55;
        vecs[5] = '0; vecs[5].skip = 10'd4;
        vecs[5].peds[0] = 16'd0;    vecs[5].sigs[0] = -16'sd5;
        vecs[5].peds[1] = 16'd10;   vecs[5].sigs[1] = 16'd3;
        vecs[5].peds[2] = -16'sd7;  vecs[5].sigs[2] = -16'sd7;
        vecs[5].peds[3] = 16'd1000; vecs[5].sigs[3] = 16'd2000;
        vecs[5].exp_data = 32'd988;

        tick(); tick();
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_pix_data", int'(pix_data), 0);
        chk("rst_pix_index", int'(pix_index), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_protocol_err", int'(protocol_err), 0);
        chk("rst_overrun_err", int'(overrun_err), 0);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            skip_samples = vecs[v].skip;
            n = (vecs[v].skip == 10'd0) ? 1 : int'(vecs[v].skip);
            for (int p = 0; p < n; p++) begin
                do_pair(vecs[v].peds[p], vecs[v].sigs[p]);
                chk($sformatf("v%0d_p%0d_no_early_valid", v, p), int'(pix_valid), 0);
            end
            tick();
            chk($sformatf("v%0d_valid", v), int'(pix_valid), 1);
            chk($sformatf("v%0d_data", v), int'(pix_data), int'(vecs[v].exp_data));
            chk($sformatf("v%0d_index", v), int'(pix_index), exp_index);
            chk($sformatf("v%0d_busy", v), int'(busy), 0);
            exp_index++;
            tick();
            chk($sformatf("v%0d_valid_drop", v), int'(pix_valid), 0);
        end

        // adc_valid held low for 7 cycles while armed for SIG
        skip_samples = 10'd1;
        sprocket_PED = 1'b1; adc_valid = 1'b1; adc_data = 16'd100;
        tick(); tick();
        sprocket_PED = 1'b0; adc_valid = 1'b0;
        tick();
        sprocket_SIG = 1'b1; adc_data = 16'd9999;
        tick();
        repeat (7) tick();
        chk("delay_busy", int'(busy), 1);
        chk("delay_no_valid", int'(pix_valid), 0);
        adc_valid = 1'b1; adc_data = 16'd175;
        tick();
        sprocket_SIG = 1'b0; adc_valid = 1'b0;
        tick();
        chk("delay_valid", int'(pix_valid), 1);
        chk("delay_data", int'(pix_data), 75);
        chk("delay_index", int'(pix_index), exp_index);
        exp_index++;
        tick();

        // overrun: second result dropped while the first is held
        pix_ready = 1'b0;
        do_pair(16'd10, 16'd30);
        tick();
        chk("ovr_first_data", int'(pix_data), 20);
        do_pair(16'd0, 16'd5);
        tick();
        chk("ovr_flag", int'(overrun_err), 1);
        chk("ovr_held_valid", int'(pix_valid), 1);
        chk("ovr_held_data", int'(pix_data), 20);
        chk("ovr_held_index", int'(pix_index), exp_index);
        pix_ready = 1'b1;
        tick();
        chk("ovr_accept_drop", int'(pix_valid), 0);
        exp_index++;
        pulse_clear();
        chk("ovr_cleared", int'(overrun_err), 0);

        // accept and publish on the same edge keeps pix_valid high
        pix_ready = 1'b0;
        do_pair(16'd0, 16'd40);
        tick(); tick(); tick();
        chk("b2b_first_data", int'(pix_data), 40);
        do_pair(16'd0, -16'sd8);
        pix_ready = 1'b1;
        tick();
        chk("b2b_valid", int'(pix_valid), 1);
        chk("b2b_data", int'(pix_data), -8);
        chk("b2b_index", int'(pix_index), exp_index + 1);
        chk("b2b_no_overrun", int'(overrun_err), 0);
        exp_index += 2;
        tick();
        chk("b2b_drop", int'(pix_valid), 0);

        // protocol errors in IDLE
        sprocket_SIG = 1'b1;
        tick();
        chk("sig_idle_err", int'(protocol_err), 1);
        chk("sig_idle_busy", int'(busy), 0);
        sprocket_SIG = 1'b0;
        pulse_clear();
        chk("sig_idle_clear", int'(protocol_err), 0);
        sprocket_PED = 1'b1; sprocket_SIG = 1'b1;
        tick();
        chk("both_err", int'(protocol_err), 1);
        chk("both_busy", int'(busy), 0);
        sprocket_PED = 1'b0; sprocket_SIG = 1'b0;
        tick();
        pulse_clear();
        chk("both_clear", int'(protocol_err), 0);
        sprocket_SIG = 1'b1; clear_err = 1'b1;
        tick();
        clear_err = 1'b0; sprocket_SIG = 1'b0;
        chk("set_wins_clear", int'(protocol_err), 1);
        pulse_clear();

        // SIG edge in ARM_PED flagged and ignored; pixel still completes
        sprocket_PED = 1'b1; adc_valid = 1'b0;
        tick();
        sprocket_SIG = 1'b1;
        tick();
        chk("sig_armped_err", int'(protocol_err), 1);
        chk("sig_armped_busy", int'(busy), 1);
        sprocket_PED = 1'b0; sprocket_SIG = 1'b0; adc_valid = 1'b1; adc_data = 16'd0;
        tick();
        sprocket_SIG = 1'b1; adc_data = 16'd3;
        tick(); tick();
        sprocket_SIG = 1'b0; adc_valid = 1'b0;
        tick();
        chk("sig_armped_data", int'(pix_data), 3);
        chk("sig_armped_index", int'(pix_index), exp_index);
        exp_index++;
        tick();

        // reset in WAIT_SIG after 5 of 10 skips
        skip_samples = 10'd10;
        for (int i = 0; i < 5; i++) do_pair(16'(i), 16'(i + 500));
        chk("mid_busy", int'(busy), 1);
        reset = 1'b1;
        #2;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_data", int'(pix_data), 0);
        chk("mid_rst_index", int'(pix_index), 0);
        chk("mid_rst_proto", int'(protocol_err), 0);
        tick();
        reset = 1'b0;
        tick();
        chk("mid_rst_no_valid", int'(pix_valid), 0);
        exp_index = 0;
        for (int p = 0; p < 10; p++) do_pair(vecs[4].peds[p], vecs[4].sigs[p]);
        tick();
        chk("post_rst_valid", int'(pix_valid), 1);
        chk("post_rst_data", int'(pix_data), 55);
        chk("post_rst_index", int'(pix_index), 0);
        tick();

        // strobe already high when reset releases counts as an edge
        sprocket_PED = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("rel_edge_busy", int'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0; sprocket_PED = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
